dff_capture_arbiter: RTL and testbench

- Round-robin arbiter that shares one WIDTH-bit D-flip-flop capture register between NREQ requesters.
- Each requester raises req with its data. The winner is granted the register for HOLD cycles, and its data is captured at the end of the hold.
- Sits between multiple producer blocks and the shared capture register bank in the tile.
- Outputs the captured value, the index of the requester it came from, and a one-cycle valid pulse.

---
 rtl/dff_capture_arbiter.sv | 134 +++++++++++++
 tb/tb_dff_capture_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dff_capture_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit capture register between NREQ requesters.
// The winner holds the grant for HOLD cycles; its data is captured at the end of the hold.
module dff_capture_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned HOLD  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en_i,
    input  logic [NREQ-1:0]         req_i,
    input  logic [NREQ*WIDTH-1:0]   data_i,
    output logic [NREQ-1:0]         gnt_o,
    output logic [WIDTH-1:0]        q_o,
    output logic [$clog2(NREQ)-1:0] q_src_o,
    output logic                    q_valid_o,
    output logic                    busy_o
);

    localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CNT_W = (HOLD > 1) ? $clog2(HOLD) : 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] win_q, win_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [IDX_W-1:0] src_q, src_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;

    logic [WIDTH-1:0] data_arr [NREQ];
    logic             found_c;
    logic [IDX_W-1:0] pick_c;

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign data_arr[g] = data_i[g*WIDTH +: WIDTH];
    end

    // Rotating priority: first set request scanning upward from ptr+1.
    always_comb begin
        int unsigned k;
        k       = 0;
        found_c = 1'b0;
        pick_c  = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            k = (32'(ptr_q) + i) % NREQ;
            if (!found_c && req_i[IDX_W'(k)]) begin
                found_c = 1'b1;
                pick_c  = IDX_W'(k);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        win_d   = win_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        cap_d   = cap_q;
        src_d   = src_q;
        valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                gnt_d = '0;
                if (en_i && found_c) begin
                    win_d         = pick_c;
                    gnt_d[pick_c] = 1'b1;
                    cnt_d         = CNT_W'(HOLD - 1);
                    state_d       = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // Enable low freezes the hold entirely, including abort detection.
                if (en_i) begin
                    if (!req_i[win_q]) begin
                        gnt_d   = '0;
                        state_d = ST_IDLE;
                    end else if (cnt_q != '0) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        cap_d   = data_arr[win_q];
                        src_d   = win_q;
                        ptr_d   = win_q;
                        valid_d = 1'b1;
                        gnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d == ST_HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            win_q   <= '0;
            ptr_q   <= IDX_W'(NREQ - 1);
            gnt_q   <= '0;
            cap_q   <= '0;
            src_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            win_q   <= win_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            cap_q   <= cap_d;
            src_q   <= src_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign gnt_o     = gnt_q;
    assign q_o       = cap_q;
    assign q_src_o   = src_q;
    assign q_valid_o = valid_q;
    assign busy_o    = busy_q;

endmodule

// File: tb/tb_dff_capture_arbiter.sv
// Directed bench for dff_capture_arbiter: expected captures are queued as stimulus is
// driven and matched against each q_valid pulse; gnt shape is checked every cycle.
module tb_dff_capture_arbiter;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned HOLD  = 2;

    typedef struct packed {
        logic [WIDTH-1:0] q;
        logic [1:0]       src;
    } cap_t;

    logic                  clk;
    logic                  rst;
    logic                  en;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] data;
    logic [NREQ-1:0]       gnt;
    logic [WIDTH-1:0]      q;
    logic [1:0]            q_src;
    logic                  q_valid;
    logic                  busy;

    int   checks = 0;
    int   errors = 0;
    cap_t sb[$];

    dff_capture_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .HOLD(HOLD)) dut (
        .clk      (clk),
        .rst      (rst),
        .en_i     (en),
        .req_i    (req),
        .data_i   (data),
        .gnt_o    (gnt),
        .q_o      (q),
        .q_src_o  (q_src),
        .q_valid_o(q_valid),
        .busy_o   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_data(input int unsigned idx, input logic [WIDTH-1:0] v);
        data[idx*WIDTH +: WIDTH] = v;
    endtask

    task automatic push(input logic [WIDTH-1:0] v, input logic [1:0] s);
        cap_t c;
        c.q   = v;
        c.src = s;
        sb.push_back(c);
    endtask

    // Per-cycle monitor: grant shape, valid/grant exclusion, scoreboard match.
    always @(negedge clk) begin
        cap_t e;
        checks++;
        assert ($onehot0(gnt)) else begin
            errors++;
            $error("FAIL gnt_onehot: observed %b expected zero or one-hot", gnt);
        end
        checks++;
        assert (!(q_valid && (gnt != '0))) else begin
            errors++;
            $error("FAIL valid_vs_gnt: observed q_valid=%b gnt=%b expected no overlap", q_valid, gnt);
        end
        if (q_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $error("FAIL sb_unexpected: observed capture q=%0h src=%0d expected none", q, q_src);
            end else begin
                e = sb.pop_front();
                assert ({q, q_src} === {e.q, e.src}) else begin
                    errors++;
                    $error("FAIL sb_capture: observed q=%0h src=%0d expected q=%0h src=%0d",
                           q, q_src, e.q, e.src);
                end
            end
        end
    end

    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        req  = '0;
        data = '0;
        step();
        step();
        chk("reset_gnt", 32'(gnt), 0);
        chk("reset_q", 32'(q), 0);
        chk("reset_src", 32'(q_src), 0);
        chk("reset_valid", 32'(q_valid), 0);
        chk("reset_busy", 32'(busy), 0);
        rst = 1'b0;
        step();

        // Single request from requester 1
        req = 4'b0010;
        set_data(1, 8'hA5);
        en = 1'b1;
        push(8'hA5, 2'd1);
        step();
        chk("single_gnt_c1", 32'(gnt), 32'h2);
        chk("single_busy_c1", 32'(busy), 1);
        step();
        chk("single_gnt_c2", 32'(gnt), 32'h2);
        step();
        chk("single_gnt_c3", 32'(gnt), 0);
        chk("single_q", 32'(q), 32'hA5);
        chk("single_src", 32'(q_src), 1);
        chk("single_valid", 32'(q_valid), 1);
        req = '0;
        step();
        chk("single_valid_drop", 32'(q_valid), 0);
        chk("single_busy_after", 32'(busy), 0);
        chk("single_q_hold", 32'(q), 32'hA5);

        // Fresh pointer, then all four requesting continuously
        @(negedge clk);
        rst = 1'b1;
        #1;
        rst = 1'b0;
        step();
        set_data(0, 8'h10);
        set_data(1, 8'h20);
        set_data(2, 8'h30);
        set_data(3, 8'h40);
        for (int k = 0; k < 5; k++) push(8'(8'h10 * ((k % 4) + 1)), 2'(k % 4));
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("rr_gnt_a", 32'(gnt), 32'(1) << (k % 4));
            step();
            chk("rr_gnt_b", 32'(gnt), 32'(1) << (k % 4));
            step();
            chk("rr_gap", 32'(gnt), 0);
            chk("rr_valid", 32'(q_valid), 1);
            chk("rr_q", 32'(q), 32'(8'h10 * ((k % 4) + 1)));
        end
        req = '0;
        step();

        // Abort: capture from 2 first, then abort a second grant to 2
        req = 4'b0100;
        set_data(2, 8'h5A);
        push(8'h5A, 2'd2);
        step();
        step();
        step();
        chk("abort_pre_q", 32'(q), 32'h5A);
        step();
        chk("abort_gnt", 32'(gnt), 32'h4);
        req = '0;
        step();
        chk("abort_gnt_drop", 32'(gnt), 0);
        chk("abort_valid", 32'(q_valid), 0);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_q_kept", 32'(q), 32'h5A);
        req = 4'b1111;
        push(8'h40, 2'd3);
        step();
        chk("abort_next_winner", 32'(gnt), 32'h8);
        step();
        step();
        chk("abort_next_q", 32'(q), 32'h40);
        req = '0;
        step();

        // Enable gating
        en  = 1'b0;
        req = 4'b1111;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("en_idle_gnt", 32'(gnt), 0);
            chk("en_idle_busy", 32'(busy), 0);
        end
        en = 1'b1;
        push(8'h10, 2'd0);
        step();
        chk("en_gnt_start", 32'(gnt), 32'h1);
        en = 1'b0;
        step();
        chk("en_freeze_1", 32'(gnt), 32'h1);
        step();
        chk("en_freeze_2", 32'(gnt), 32'h1);
        chk("en_freeze_valid", 32'(q_valid), 0);
        en = 1'b1;
        step();
        chk("en_resume", 32'(gnt), 32'h1);
        chk("en_resume_valid", 32'(q_valid), 0);
        step();
        chk("en_capture_valid", 32'(q_valid), 1);
        chk("en_capture_q", 32'(q), 32'h10);
        req = '0;
        step();

        // Async reset mid-hold
        req = 4'b0010;
        set_data(1, 8'h20);
        step();
        chk("rst_pre_gnt", 32'(gnt), 32'h2);
        step();
        #2;
        rst = 1'b1;
        #1;
        chk("rst_async_gnt", 32'(gnt), 0);
        chk("rst_async_busy", 32'(busy), 0);
        chk("rst_async_q", 32'(q), 0);
        step();
        chk("rst_no_capture", 32'(q_valid), 0);
        #4;
        rst = 1'b0;
        req = 4'b1000;
        step();
        chk("rst_first_3", 32'(gnt), 32'h8);
        req = '0;
        step();
        #2;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        req = 4'b1111;
        step();
        chk("rst_first_0", 32'(gnt), 32'h1);
        req = '0;
        step();
        step();

        // Data change during hold: captured value is the one present at the capture edge
        req = 4'b0010;
        set_data(1, 8'h11);
        push(8'h22, 2'd1);
        step();
        chk("dchg_gnt", 32'(gnt), 32'h2);
        set_data(1, 8'h22);
        step();
        step();
        chk("dchg_valid", 32'(q_valid), 1);
        chk("dchg_q", 32'(q), 32'h22);
        chk("dchg_src", 32'(q_src), 1);
        req = '0;
        step();
        step();
        step();

        chk("sb_empty", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
